// File: rtl/cp0_if.sv
// CP0 pipeline-side bus: M-stage exception/interrupt inputs, mtc0/mfc0 access and flush outputs.
// Latency: not applicable; this file only bundles the signals.
// Backpressure: none; the flush request is combinational and cannot be stalled.
interface cp0_if;
  logic [31:0] pc_m;
  logic [4:0]  exc_code_m;
  logic        bd_m;
  logic [5:0]  hw_int;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        cp0_we;
  logic        eret_m;
  logic        int_req;
  logic [31:0] epc;
  logic [31:0] cp0_rdata;

  // Pipeline side drives the M-stage request signals and observes the flush/read results
  modport master (
    output pc_m, exc_code_m, bd_m, hw_int, cp0_addr, cp0_wdata, cp0_we, eret_m,
    input  int_req, epc, cp0_rdata
  );

  // CP0 side
  modport slave (
    input  pc_m, exc_code_m, bd_m, hw_int, cp0_addr, cp0_wdata, cp0_we, eret_m,
    output int_req, epc, cp0_rdata
  );
endinterface

// File: rtl/cp0.sv
// CP0 (SR/Cause/EPC/PRId): takes interrupts and exceptions from the M stage, and handles mtc0, mfc0 and eret.
// Latency: int_req and cp0_rdata are combinational; register updates land on the next clk edge.
// Backpressure: none; a taken event blocks a same-cycle mtc0 or eret. CP0_EXC_EN enables synchronous exceptions.
module cp0 (
  input  logic  clk,
  input  logic  reset,
  cp0_if.slave  bus
);

  localparam logic [31:0] PRID       = 32'h4350_3037;
  localparam logic [4:0]  ADDR_SR    = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE = 5'd13;
  localparam logic [4:0]  ADDR_EPC   = 5'd14;
  localparam logic [4:0]  ADDR_PRID  = 5'd15;

  logic [5:0]  sr_im_q, sr_im_d;
  logic        sr_exl_q, sr_exl_d;
  logic        sr_ie_q, sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;

  logic        int_pend;
  logic        exc_pend;
  logic        take;
  logic [4:0]  rec_code;
  logic [31:0] sr_val;
  logic [31:0] cause_val;
  logic [31:0] rdata;

  // Detect pending events; an interrupt wins and records ExcCode 0. Held off while reset is active.
  always_comb begin
    int_pend = (|(bus.hw_int & sr_im_q)) & sr_ie_q & ~sr_exl_q;
`ifdef CP0_EXC_EN
    exc_pend = (bus.exc_code_m != 5'd0) & ~sr_exl_q;
    rec_code = int_pend ? 5'd0 : bus.exc_code_m;
`else
    exc_pend = 1'b0;
    rec_code = 5'd0;
`endif
    take = ~reset & (int_pend | exc_pend);
  end

  // Next state: a taken event overrides mtc0 and eret; Cause.IP samples the lines every edge.
  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = bus.hw_int;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    if (take) begin
      sr_exl_d    = 1'b1;
      cause_exc_d = rec_code;
      cause_bd_d  = bus.bd_m;
      epc_d       = bus.bd_m ? (bus.pc_m - 32'd4) : bus.pc_m;
    end else begin
      if (bus.cp0_we) begin
        if (bus.cp0_addr == ADDR_SR) begin
          sr_im_d  = bus.cp0_wdata[15:10];
          sr_exl_d = bus.cp0_wdata[1];
          sr_ie_d  = bus.cp0_wdata[0];
        end else if (bus.cp0_addr == ADDR_EPC) begin
          epc_d = bus.cp0_wdata;
        end
      end
      // eret is applied last so it always leaves the handler, even alongside an SR write
      if (bus.eret_m) begin
        sr_exl_d = 1'b0;
      end
    end
  end

  // Register state; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_im_q     <= 6'd0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= 6'd0;
      cause_exc_q <= 5'd0;
      epc_q       <= 32'd0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  // mfc0 read mux; no bypass of a same-cycle mtc0.
  always_comb begin
    sr_val    = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
    cause_val = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
    rdata     = 32'd0;
    case (bus.cp0_addr)
      ADDR_SR:    rdata = sr_val;
      ADDR_CAUSE: rdata = cause_val;
      ADDR_EPC:   rdata = epc_q;
      ADDR_PRID:  rdata = PRID;
      default:    rdata = 32'd0;
    endcase
  end

  assign bus.int_req   = take;
  assign bus.epc       = epc_q;
  assign bus.cp0_rdata = rdata;

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 clk  input  1  system clock; all state updates on the rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 pc_m  input  32  PC of the instruction in the M stage.
REQ-004 exc_code_m  input  5  exception code carried with the M-stage instruction; 0 = none.
REQ-005 bd_m  input  1  1 = M-stage instruction is in a branch delay slot.
REQ-006 hw_int  input  6  external interrupt lines, level-sensitive.
REQ-007 cp0_addr  input  5  CP0 register number for mtc0 and mfc0.
REQ-008 cp0_wdata  input  32  mtc0 write data.
REQ-009 cp0_we  input  1  mtc0 in M stage, write enable.
REQ-010 eret_m  input  1  eret in M stage.
REQ-011 int_req  output  1  flush request to the pipeline registers; the PC redirects to 0x0000_4180.
REQ-012 epc  output  32  current EPC register value; the eret return target.
REQ-013 cp0_rdata  output  32  mfc0 read data.

Function
REQ-014 Registers:
- SR (12): IM = bits 15:10, EXL = bit 1, IE = bit 0; all other bits read 0.
- Cause (13): BD = bit 31, IP = bits 15:10, ExcCode = bits 6:2; other bits read 0.
- EPC (14): full 32 bits.
- PRId (15): constant 0x4350_3037.
REQ-015 int_pend = |(hw_int & SR.IM) & SR.IE & ~SR.EXL.
REQ-016 exc_pend = (exc_code_m != 0) & ~SR.EXL.
REQ-017 int_req is combinational and equals int_pend | exc_pend, with no latency; the pipeline flushes on the same edge.
REQ-018 Interrupt takes priority over exception:
- int_pend: recorded ExcCode = 0.
- exc_pend only: recorded ExcCode = exc_code_m.
REQ-019 On an edge with int_req = 1:
- EXL <= 1.
- Cause.ExcCode <= code per REQ-018.
- Cause.BD <= bd_m.
- EPC <= bd_m ? pc_m - 4 : pc_m, using 32-bit modulo subtraction.
REQ-020 Cause.IP <= hw_int on every edge, regardless of EXL or IE.
REQ-021 mtc0 when cp0_we = 1 and int_req = 0:
- Address 12 writes SR bits 15:10, 1 and 0.
- Address 14 writes EPC.
- Addresses 13 and 15 and all other addresses are ignored.
REQ-022 eret_m = 1 and int_req = 0 causes EXL <= 0 on the edge; EPC is unchanged.
REQ-023 Simultaneous events:
- int_req = 1 blocks both the mtc0 write and the eret in the same cycle.
- With EXL = 1, int_req stays 0 even if exc_code_m != 0 or an enabled interrupt is pending.
REQ-024 cp0_rdata is a combinational read by cp0_addr: 12 SR, 13 Cause, 14 EPC, 15 PRId, otherwise 0.
- No write-to-read bypass; a same-cycle mtc0 is visible on the next cycle.
REQ-025 epc always reflects the registered EPC.

Reset
REQ-026 While reset = 1, asynchronously:
- SR, Cause and EPC = 0.
- int_req = 0.
- cp0_rdata follows REQ-024 with the cleared values.
REQ-027 An interrupt or exception asserted during reset is not recorded; evaluation restarts from the first edge after reset deasserts.

Configuration
REQ-028 Macro CP0_EXC_EN.
- Defined: synchronous exceptions are handled per REQ-016 to REQ-019.
- Undefined: exc_pend is forced to 0, exc_code_m is ignored, and only interrupts raise int_req (Cause.ExcCode is always written as 0).

Verification
REQ-029 Reset, then SR <= 0x0000_0401 via mtc0, then hw_int = 6'b000001 with pc_m = 0x0000_3008 and bd_m = 0:
- int_req = 1 in the same cycle.
- After the edge: EPC = 0x0000_3008, SR reads 0x0000_0403, Cause reads 0x0000_0400.
REQ-030 SR = 0, exc_code_m = 5'd4, pc_m = 0x0000_3011, bd_m = 1:
- int_req = 1.
- After the edge: EPC = 0x0000_300D, Cause reads 0x8000_0010.
- With CP0_EXC_EN undefined, int_req = 0 and nothing changes.
REQ-031 With EXL = 1, exc_code_m = 5'd12 and enabled hw_int asserted:
- int_req = 0; EPC and ExcCode are unchanged.
- eret_m = 1 for one cycle clears EXL; the pending interrupt then raises int_req in the next cycle.
REQ-032 cp0_we = 1, cp0_addr = 14, cp0_wdata = 0x1234_5678 in the same cycle as a taken interrupt (pc_m = 0x0000_3000):
- EPC = 0x0000_3000 after the edge; the write is dropped.
REQ-033 Read sweep cp0_addr = 12..16 after reset:
- Returns 0, 0, 0, 0x4350_3037, 0.
- Asserting reset mid-handler (EXL = 1) clears SR and EPC with no clock edge.
